// File: rtl/lcd_cfah_bus_ctrl_if.sv
// rtl/lcd_cfah_bus_ctrl_if.sv - host request/response handshake for the CFAH LCD bus controller
interface lcd_cfah_bus_ctrl_if;
    logic       i_start;
    logic       i_rs;
    logic       i_rw;
    logic [7:0] i_wdata;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_rdata;
    logic       o_rdata_val;

    modport master (
        output i_start, i_rs, i_rw, i_wdata,
        input  o_busy, o_done, o_rdata, o_rdata_val
    );

    modport slave (
        input  i_start, i_rs, i_rw, i_wdata,
        output o_busy, o_done, o_rdata, o_rdata_val
    );
endinterface

// File: rtl/lcd_cfah_bus_ctrl.sv
// rtl/lcd_cfah_bus_ctrl.sv - HD44780-style 8-bit bus cycle generator (RS/RW/EN/DATA timing)
module lcd_cfah_bus_ctrl #(
    parameter int T_AS_CYC   = 3,
    parameter int T_PWEH_CYC = 13,
    parameter int T_AH_CYC   = 1,
    parameter int T_CYCE_CYC = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    lcd_cfah_bus_ctrl_if.slave   bus,
    output logic                 o_lcd_rs,
    output logic                 o_lcd_rw,
    output logic                 o_lcd_en,
    inout  wire  [7:0]           io_lcd_data
);

    localparam int T_WAIT = (T_CYCE_CYC > T_PWEH_CYC + T_AH_CYC) ?
                            (T_CYCE_CYC - T_PWEH_CYC - T_AH_CYC) : 0;
    localparam int MAX_A  = (T_AS_CYC > T_PWEH_CYC) ? T_AS_CYC : T_PWEH_CYC;
    localparam int MAX_B  = (T_AH_CYC > T_WAIT) ? T_AH_CYC : T_WAIT;
    localparam int MAX_P  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW     = $clog2(MAX_P + 1);

    // Counters are loaded with duration-1 so the state lasts exactly "duration" cycles.
    localparam logic [CW-1:0] AS_LD   = CW'((T_AS_CYC   > 0) ? T_AS_CYC   - 1 : 0);
    localparam logic [CW-1:0] PWEH_LD = CW'((T_PWEH_CYC > 0) ? T_PWEH_CYC - 1 : 0);
    localparam logic [CW-1:0] AH_LD   = CW'((T_AH_CYC   > 0) ? T_AH_CYC   - 1 : 0);
    localparam logic [CW-1:0] WAIT_LD = CW'((T_WAIT     > 0) ? T_WAIT     - 1 : 0);

    typedef enum logic [2:0] {IDLE, SETUP, ENABLE, HOLD, WAIT} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          rs_q, rw_q, en_q, drive_q, busy_q, done_q, rdata_val_q;
    logic [7:0]    wdata_q, rdata_q;

    always_ff @(posedge clk) begin
        done_q      <= 1'b0;
        rdata_val_q <= 1'b0;
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            en_q    <= 1'b0;
            drive_q <= 1'b0;
            busy_q  <= 1'b0;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_start) begin
                        rs_q    <= bus.i_rs;
                        rw_q    <= bus.i_rw;
                        wdata_q <= bus.i_wdata;
                        drive_q <= ~bus.i_rw;
                        busy_q  <= 1'b1;
                        if (T_AS_CYC > 0) begin
                            state_q <= SETUP;
                            cnt_q   <= AS_LD;
                        end else begin
                            state_q <= ENABLE;
                            en_q    <= 1'b1;
                            cnt_q   <= PWEH_LD;
                        end
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        state_q <= ENABLE;
                        en_q    <= 1'b1;
                        cnt_q   <= PWEH_LD;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ENABLE: begin
                    if (cnt_q == '0) begin
                        en_q <= 1'b0;
                        if (rw_q) rdata_q <= io_lcd_data;
                        if (T_AH_CYC > 0) begin
                            state_q <= HOLD;
                            cnt_q   <= AH_LD;
                        end else if (T_WAIT > 0) begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_LD;
                            drive_q <= 1'b0;
                        end else begin
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            rdata_val_q <= rw_q;
                            drive_q     <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        drive_q <= 1'b0;
                        if (T_WAIT > 0) begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_LD;
                        end else begin
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            rdata_val_q <= rw_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        rdata_val_q <= rw_q;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_rdata     = rdata_q;
    assign bus.o_rdata_val = rdata_val_q;
    assign o_lcd_rs        = rs_q;
    assign o_lcd_rw        = rw_q;
    assign o_lcd_en        = en_q;
    assign io_lcd_data     = drive_q ? wdata_q : 8'bz;

endmodule
